nt_subckt_bist_ctrl: RTL and testbench

//  Built-in self-test sequencer for one extracted Nt-node subcircuit (5-input, 1-output, 3-flop-deep CUT).

---
 rtl/nt_bist_pkg.sv | 17 +
 rtl/nt_bist_lfsr.sv | 38 +++
 rtl/nt_subckt_bist_ctrl.sv | 132 +++++++++++++
 tb/tb_nt_subckt_bist_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nt_bist_pkg.sv
// Shared types and constants for the Nt-node subcircuit BIST controller.
// Holds the FSM state encoding, the LFSR/MISR tap mask and the fallback seed.
package nt_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    RUN,
    CMP,
    DONE
  } state_t;

  // x^16 + x^14 + x^13 + x^11 + 1 -> taps on bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/nt_bist_lfsr.sv
// Fibonacci shift register usable as a pattern LFSR (compact=0) or a MISR.
// Ports: clk, rst_n (sync, active-low), load/load_val, step, compact/din, q_lo.
module nt_bist_lfsr
  import nt_bist_pkg::*;
#(
  parameter int SIG_W = 16,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [SIG_W-1:0] load_val,
  input  logic             step,
  input  logic             compact,
  input  logic             din,
  output logic [OUT_W-1:0] q_lo
);

  logic [SIG_W-1:0] q;
  logic             fb;
  logic [SIG_W-1:0] q_nxt;

  assign fb    = ^(q & LFSR_TAPS);
  assign q_nxt = {q[SIG_W-2:0], fb}
               ^ {{(SIG_W-1){1'b0}}, compact & din};
  assign q_lo  = q[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (step) begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/nt_subckt_bist_ctrl.sv
// BIST sequencer: seeds the CUT, drives LFSR patterns, compacts into a MISR.
// Ports: I1470_clk, I1477_rst, start, abort, seed, n_pat, golden, cut_in,
//        cut_rst_n, cut_out, busy, done, pass, signature.
module nt_subckt_bist_ctrl
  import nt_bist_pkg::*;
#(
  parameter int N_IN  = 5,
  parameter int LAT   = 3,
  parameter int CNT_W = 10,
  parameter int SIG_W = 16
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] seed,
  input  logic [CNT_W-1:0] n_pat,
  input  logic [SIG_W-1:0] golden,
  output logic [N_IN-1:0]  cut_in,
  output logic             cut_rst_n,
  input  logic             cut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  localparam logic [CNT_W:0] LAT_W = (CNT_W+1)'(LAT);

  state_t           state;
  state_t           state_nxt;
  logic [SIG_W-1:0] seed_q;
  logic [CNT_W-1:0] npat_q;
  logic [CNT_W:0]   cnt;
  logic [CNT_W:0]   run_last;
  logic [SIG_W-1:0] misr;
  logic             misr_cap;

  // One extra bit so n_pat + LAT never wraps
  assign run_last = {1'b0, npat_q} + LAT_W - 1'b1;
  // First LAT cycles of RUN only fill the CUT pipeline
  assign misr_cap = (state == RUN) && (cnt >= LAT_W);

  always_ff @(posedge I1470_clk) begin
    if (!I1477_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (start) state_nxt = SEED;
        SEED: state_nxt = (npat_q == '0) ? CMP : RUN;
        RUN:  if (cnt == run_last) state_nxt = CMP;
        CMP:  state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = 1'b1;
    done      = 1'b0;
    cut_rst_n = 1'b0;
    unique case (state)
      IDLE:    busy = 1'b0;
      RUN:     cut_rst_n = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge I1470_clk) begin
    if (!I1477_rst) begin
      seed_q    <= '0;
      npat_q    <= '0;
      cnt       <= '0;
      pass      <= 1'b0;
      signature <= '0;
    end else begin
      if (state == IDLE && start && !abort) begin
        seed_q <= (seed == '0) ? DEFAULT_SEED : seed;
        npat_q <= n_pat;
      end
      if (state == SEED) begin
        cnt <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
      end
      if (state == CMP && !abort) begin
        signature <= misr;
        pass      <= (misr == golden);
      end
    end
  end

  nt_bist_lfsr #(
    .SIG_W (SIG_W),
    .OUT_W (N_IN)
  ) u_pat (
    .clk      (I1470_clk),
    .rst_n    (I1477_rst),
    .load     (state == SEED),
    .load_val (seed_q),
    .step     (state == RUN),
    .compact  (1'b0),
    .din      (1'b0),
    .q_lo     (cut_in)
  );

  nt_bist_lfsr #(
    .SIG_W (SIG_W),
    .OUT_W (SIG_W)
  ) u_misr (
    .clk      (I1470_clk),
    .rst_n    (I1477_rst),
    .load     (state == SEED),
    .load_val ('0),
    .step     (misr_cap),
    .compact  (1'b1),
    .din      (cut_out),
    .q_lo     (misr)
  );

endmodule

// File: tb/tb_nt_subckt_bist_ctrl.sv
// Self-checking bench for nt_subckt_bist_ctrl with a 3-deep XOR CUT model.
// Table-driven runs through a scoreboard queue plus hand-written corner cases.
module tb_nt_subckt_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] seed = '0;
  logic [9:0]  n_pat = '0;
  logic [15:0] golden = '0;
  logic [4:0]  cut_in;
  logic        cut_rst_n;
  logic        cut_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;

  int          mode = 0;
  logic [2:0]  pipe = '0;

  int checks = 0;
  int failures = 0;

  logic [15:0] last_sig = '0;
  logic        last_pass = 1'b0;

  typedef struct {
    logic [15:0] seed;
    int          n;
    int          mode;
    logic [15:0] gxor;
    bit          has_ref;
    logic [15:0] ref_sig;
    bit          mid_start;
  } vec_t;

  typedef struct {
    logic [15:0] sig;
    logic        pass;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  // CUT stand-in: parity of the 5 inputs through 3 flops
  always @(posedge clk) begin
    if (!cut_rst_n) pipe <= '0;
    else pipe <= {pipe[1:0], ^cut_in};
  end

  assign cut_out = (mode == 0) ? 1'b0 :
                   (mode == 1) ? 1'b1 : pipe[2];

  nt_subckt_bist_ctrl dut (
    .I1470_clk (clk),
    .I1477_rst (rst_n),
    .start     (start),
    .abort     (abort),
    .seed      (seed),
    .n_pat     (n_pat),
    .golden    (golden),
    .cut_in    (cut_in),
    .cut_rst_n (cut_rst_n),
    .cut_out   (cut_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] model_sig(input logic [15:0] s,
                                            input int n, input int md);
    logic [15:0] l;
    logic [15:0] m;
    logic        b;
    l = (s == 16'h0) ? 16'hACE1 : s;
    m = '0;
    for (int k = 0; k < n; k++) begin
      b = (md == 0) ? 1'b0 : (md == 1) ? 1'b1 : ^l[4:0];
      m = {m[14:0], ^(m & 16'hB400)} ^ {15'b0, b};
      l = {l[14:0], ^(l & 16'hB400)};
    end
    return m;
  endfunction

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while (busy && c < 3000) begin
      step();
      c++;
    end
    chk(nm, {31'b0, busy}, 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t        e;
    logic [15:0] s;
    int          cyc;
    s      = model_sig(v.seed, v.n, v.mode);
    e.sig  = v.has_ref ? v.ref_sig : s;
    e.pass = (v.gxor == 16'h0);
    e.lat  = (v.n == 0) ? 3 : v.n + 6;
    sbq.push_back(e);
    golden = e.sig ^ v.gxor;
    seed   = v.seed;
    n_pat  = 10'(v.n);
    mode   = v.mode;
    start  = 1'b1;
    step();
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 3000) begin
      if (v.mid_start && cyc == 5) begin
        start = 1'b1;
        seed  = 16'h5555;
        n_pat = 10'd3;
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    e = sbq.pop_front();
    chk($sformatf("v%0d_done", idx), {31'b0, done}, 32'h1);
    chk($sformatf("v%0d_latency", idx), cyc, e.lat);
    chk($sformatf("v%0d_signature", idx), {16'b0, signature}, {16'b0, e.sig});
    chk($sformatf("v%0d_pass", idx), {31'b0, pass}, {31'b0, e.pass});
    step();
    chk($sformatf("v%0d_done_pulse", idx), {31'b0, done}, 32'h0);
    chk($sformatf("v%0d_busy_after", idx), {31'b0, busy}, 32'h0);
    last_sig  = e.sig;
    last_pass = e.pass;
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_busy"}, {31'b0, busy}, 32'h0);
    chk({pfx, "_done"}, {31'b0, done}, 32'h0);
    chk({pfx, "_pass"}, {31'b0, pass}, 32'h0);
    chk({pfx, "_signature"}, {16'b0, signature}, 32'h0);
    chk({pfx, "_cut_in"}, {27'b0, cut_in}, 32'h0);
    chk({pfx, "_cut_rst_n"}, {31'b0, cut_rst_n}, 32'h0);
  endtask

  initial begin
    logic [4:0] exp_in;
    bit         seen;

    vecs[0] = '{16'h0001, 4,    2, 16'h0000, 0, 16'h0000, 0};
    vecs[1] = '{16'h0000, 100,  0, 16'h0000, 1, 16'h0000, 0};
    vecs[2] = '{16'h0000, 100,  0, 16'h0001, 1, 16'h0000, 0};
    vecs[3] = '{16'h0001, 1,    1, 16'h0000, 1, 16'h0001, 0};
    vecs[4] = '{16'h0001, 2,    1, 16'h0000, 1, 16'h0003, 0};
    vecs[5] = '{16'h0001, 0,    1, 16'h0000, 1, 16'h0000, 0};
    vecs[6] = '{16'hBEEF, 37,   2, 16'h0000, 0, 16'h0000, 1};
    vecs[7] = '{16'h0000, 12,   2, 16'h0000, 0, 16'h0000, 1};
    vecs[8] = '{16'h1234, 1023, 2, 16'h8000, 0, 16'h0000, 0};

    step();
    step();
    chk_reset_outs("init");
    rst_n = 1'b1;
    step();

    // Pattern walk from seed 1
    seed  = 16'h0001;
    n_pat = 10'd4;
    mode  = 2;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("seed_busy", {31'b0, busy}, 32'h1);
    chk("seed_cut_rst_n", {31'b0, cut_rst_n}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      exp_in = 5'(1 << i);
      chk($sformatf("walk_cut_in%0d", i), {27'b0, cut_in}, {27'b0, exp_in});
    end
    chk("run_cut_rst_n", {31'b0, cut_rst_n}, 32'h1);
    wait_idle("walk_idle");

    // Zero seed falls back to 16'hACE1
    seed  = 16'h0000;
    n_pat = 10'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("zero_seed_cut_in", {27'b0, cut_in}, 32'h01);
    wait_idle("zero_seed_idle");

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // start together with abort in IDLE
    seed  = 16'h0001;
    n_pat = 10'd5;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", {31'b0, busy}, 32'h0);
    step();
    chk("start_abort_busy2", {31'b0, busy}, 32'h0);

    // Abort in the fifth RUN cycle
    n_pat = 10'd20;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("pre_abort_cut_rst_n", {31'b0, cut_rst_n}, 32'h1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_cut_rst_n", {31'b0, cut_rst_n}, 32'h0);
    seen = done;
    for (int i = 0; i < 30; i++) begin
      step();
      seen = seen | done;
    end
    chk("abort_no_done", {31'b0, seen}, 32'h0);
    chk("abort_pass_kept", {31'b0, pass}, {31'b0, last_pass});
    chk("abort_sig_kept", {16'b0, signature}, {16'b0, last_sig});

    // Reset mid-RUN clears everything
    n_pat = 10'd50;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    rst_n = 1'b0;
    step();
    step();
    chk_reset_outs("midrst");
    rst_n = 1'b1;
    step();
    chk("midrst_idle", {31'b0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
